// File: rtl/mem_arbiter.sv
// Memory-port arbiter: shares one memory controller between instruction fetch
// (IF) and the load/store buffer (LSB). LSB has priority. A starvation counter
// forces an IF grant after STARVE_MAX back-to-back LSB grants while IF waits.
// A one-cycle GAP follows every transaction. Rollback discards in-flight fetches
// and loads. All outputs are registered.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [2:0]  lsb_len,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    output logic        mc_en,
    output logic        mc_wr,
    output logic [31:0] mc_addr,
    output logic [2:0]  mc_len,
    output logic [31:0] mc_wdata,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata,
    output logic        busy
);

    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUSY_IF = 3'd1,
        ST_BUSY_LD = 3'd2,
        ST_BUSY_ST = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic          mc_en_r, mc_en_s;
    logic          mc_wr_r, mc_wr_s;
    logic [31:0]   mc_addr_r, mc_addr_s;
    logic [2:0]    mc_len_r, mc_len_s;
    logic [31:0]   mc_wdata_r, mc_wdata_s;
    logic          ic_done_r, ic_done_s;
    logic [31:0]   ic_data_r, ic_data_s;
    logic          lsb_done_r, lsb_done_s;
    logic [31:0]   lsb_rdata_r, lsb_rdata_s;
    logic          busy_r, busy_s;
    logic [CW-1:0] starve_cnt_r, starve_cnt_s;
    logic          discard_r, discard_s;
    logic          starving_s;
    logic          drop_s;

    // IF has waited through the maximum run of LSB grants
    assign starving_s = ic_req && (starve_cnt_r == STARVE_LIM);
    // Current fetch/load result must be thrown away (earlier or same-cycle rollback)
    assign drop_s     = discard_r || rollback;

    // Next-state and next-register computation
    always_comb begin
        state_s      = state_r;
        mc_en_s      = mc_en_r;
        mc_wr_s      = mc_wr_r;
        mc_addr_s    = mc_addr_r;
        mc_len_s     = mc_len_r;
        mc_wdata_s   = mc_wdata_r;
        ic_done_s    = 1'b0;
        ic_data_s    = ic_data_r;
        lsb_done_s   = 1'b0;
        lsb_rdata_s  = lsb_rdata_r;
        starve_cnt_s = starve_cnt_r;
        discard_s    = discard_r;

        case (state_r)
            ST_IDLE: begin
                if (rollback) begin
                    starve_cnt_s = {CW{1'b0}};
                end else if (lsb_req && !starving_s) begin
                    mc_addr_s  = lsb_addr;
                    mc_len_s   = lsb_len;
                    mc_wr_s    = lsb_wr;
                    mc_wdata_s = lsb_wdata;
                    if (!ic_req) begin
                        starve_cnt_s = {CW{1'b0}};
                    end else if (starve_cnt_r != STARVE_LIM) begin
                        starve_cnt_s = starve_cnt_r + CW'(1);
                    end else begin
                        starve_cnt_s = starve_cnt_r;
                    end
                    if (lsb_len == 3'd0) begin
                        // Zero-length access never touches memory
                        lsb_done_s = 1'b1;
                        state_s    = ST_GAP;
                    end else if (lsb_wr) begin
                        mc_en_s = 1'b1;
                        state_s = ST_BUSY_ST;
                    end else begin
                        mc_en_s = 1'b1;
                        state_s = ST_BUSY_LD;
                    end
                end else if (ic_req) begin
                    mc_addr_s    = ic_addr;
                    mc_len_s     = 3'd4;
                    mc_wr_s      = 1'b0;
                    mc_wdata_s   = 32'd0;
                    mc_en_s      = 1'b1;
                    starve_cnt_s = {CW{1'b0}};
                    state_s      = ST_BUSY_IF;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_BUSY_IF, ST_BUSY_LD: begin
                if (mc_done) begin
                    mc_en_s   = 1'b0;
                    discard_s = 1'b0;
                    state_s   = ST_GAP;
                    if (drop_s) begin
                        ic_done_s  = 1'b0;
                        lsb_done_s = 1'b0;
                    end else if (state_r == ST_BUSY_IF) begin
                        ic_done_s = 1'b1;
                        ic_data_s = mc_rdata;
                    end else begin
                        lsb_done_s  = 1'b1;
                        lsb_rdata_s = mc_rdata;
                    end
                end else if (rollback) begin
                    discard_s = 1'b1;
                end else begin
                    discard_s = discard_r;
                end
            end

            ST_BUSY_ST: begin
                // Stores are committed; rollback does not affect them
                if (mc_done) begin
                    mc_en_s    = 1'b0;
                    lsb_done_s = 1'b1;
                    state_s    = ST_GAP;
                end else begin
                    state_s = ST_BUSY_ST;
                end
            end

            ST_GAP: begin
                state_s = ST_IDLE;
                if (rollback) begin
                    starve_cnt_s = {CW{1'b0}};
                end else begin
                    starve_cnt_s = starve_cnt_r;
                end
            end

            default: begin
                state_s   = ST_IDLE;
                mc_en_s   = 1'b0;
                discard_s = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; rdy low freezes everything, rst wins over rdy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            mc_en_r      <= 1'b0;
            mc_wr_r      <= 1'b0;
            mc_addr_r    <= 32'd0;
            mc_len_r     <= 3'd0;
            mc_wdata_r   <= 32'd0;
            ic_done_r    <= 1'b0;
            ic_data_r    <= 32'd0;
            lsb_done_r   <= 1'b0;
            lsb_rdata_r  <= 32'd0;
            busy_r       <= 1'b0;
            starve_cnt_r <= {CW{1'b0}};
            discard_r    <= 1'b0;
        end else if (rdy) begin
            state_r      <= state_s;
            mc_en_r      <= mc_en_s;
            mc_wr_r      <= mc_wr_s;
            mc_addr_r    <= mc_addr_s;
            mc_len_r     <= mc_len_s;
            mc_wdata_r   <= mc_wdata_s;
            ic_done_r    <= ic_done_s;
            ic_data_r    <= ic_data_s;
            lsb_done_r   <= lsb_done_s;
            lsb_rdata_r  <= lsb_rdata_s;
            busy_r       <= busy_s;
            starve_cnt_r <= starve_cnt_s;
            discard_r    <= discard_s;
        end
    end

    assign mc_en     = mc_en_r;
    assign mc_wr     = mc_wr_r;
    assign mc_addr   = mc_addr_r;
    assign mc_len    = mc_len_r;
    assign mc_wdata  = mc_wdata_r;
    assign ic_done   = ic_done_r;
    assign ic_data   = ic_data_r;
    assign lsb_done  = lsb_done_r;
    assign lsb_rdata = lsb_rdata_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. The bench plays both requesters
// and the memory controller; outputs are sampled 1 ns after the rising edge.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_data;
    logic        lsb_req;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [2:0]  lsb_len;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic        mc_en;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [2:0]  mc_len;
    logic [31:0] mc_wdata;
    logic        mc_done;
    logic [31:0] mc_rdata;
    logic        busy;

    int n_cmp;
    int n_err;
    logic [31:0] last_ic;
    logic [31:0] last_lsb;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .rollback  (rollback),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_done   (ic_done),
        .ic_data   (ic_data),
        .lsb_req   (lsb_req),
        .lsb_wr    (lsb_wr),
        .lsb_addr  (lsb_addr),
        .lsb_len   (lsb_len),
        .lsb_wdata (lsb_wdata),
        .lsb_done  (lsb_done),
        .lsb_rdata (lsb_rdata),
        .mc_en     (mc_en),
        .mc_wr     (mc_wr),
        .mc_addr   (mc_addr),
        .mc_len    (mc_len),
        .mc_wdata  (mc_wdata),
        .mc_done   (mc_done),
        .mc_rdata  (mc_rdata),
        .busy      (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [31:0] d);
        mc_done  = 1'b1;
        mc_rdata = d;
        tick();
        mc_done  = 1'b0;
        mc_rdata = 32'd0;
    endtask

    task automatic wait_mc_en(input string tag);
        int k;
        k = 0;
        while (!mc_en && k < 16) begin
            tick();
            k++;
        end
        check_val(tag, {31'd0, mc_en}, 32'd1);
    endtask

    task automatic lsb_set(input logic wr, input logic [31:0] a, input logic [2:0] len, input logic [31:0] wd);
        lsb_req   = 1'b1;
        lsb_wr    = wr;
        lsb_addr  = a;
        lsb_len   = len;
        lsb_wdata = wd;
    endtask

    initial begin
        logic        exp_lsb;
        logic [31:0] d;
        n_cmp = 0; n_err = 0;
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        ic_req = 1'b0; ic_addr = 32'd0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'd0; lsb_len = 3'd0; lsb_wdata = 32'd0;
        mc_done = 1'b0; mc_rdata = 32'd0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_mc_en", {31'd0, mc_en}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_mc_addr", mc_addr, 32'd0);
        check_val("rst_ic_data", ic_data, 32'd0);

        // Single fetch
        ic_req = 1'b1; ic_addr = 32'h0000_1000;
        tick();
        check_val("t1_mc_en", {31'd0, mc_en}, 32'd1);
        check_val("t1_mc_addr", mc_addr, 32'h0000_1000);
        check_val("t1_mc_len", {29'd0, mc_len}, 32'd4);
        check_val("t1_mc_wr", {31'd0, mc_wr}, 32'd0);
        check_val("t1_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check_val("t1_hold_en", {31'd0, mc_en}, 32'd1);
        check_val("t1_no_done", {31'd0, ic_done}, 32'd0);
        respond(32'hDEAD_BEEF);
        check_val("t1_ic_done", {31'd0, ic_done}, 32'd1);
        check_val("t1_ic_data", ic_data, 32'hDEAD_BEEF);
        check_val("t1_en_off", {31'd0, mc_en}, 32'd0);
        check_val("t1_gap_busy", {31'd0, busy}, 32'd1);
        ic_req = 1'b0;
        tick();
        check_val("t1_done_off", {31'd0, ic_done}, 32'd0);
        check_val("t1_idle", {31'd0, busy}, 32'd0);
        check_val("t1_data_hold", ic_data, 32'hDEAD_BEEF);

        // Starvation-limited arbitration
        ic_req = 1'b1; ic_addr = 32'h0000_1000;
        lsb_set(1'b0, 32'h0000_2000, 3'd4, 32'd0);
        for (int i = 0; i < 10; i++) begin
            wait_mc_en("t2_en");
            exp_lsb = ((i % 5) != 4);
            check_val("t2_grant", mc_addr, exp_lsb ? 32'h0000_2000 : 32'h0000_1000);
            d = 32'hA000_0000 + 32'(i);
            respond(d);
            if (exp_lsb) begin
                check_val("t2_lsb_done", {31'd0, lsb_done}, 32'd1);
                check_val("t2_lsb_rdata", lsb_rdata, d);
                last_lsb = d;
            end else begin
                check_val("t2_ic_done", {31'd0, ic_done}, 32'd1);
                check_val("t2_ic_data", ic_data, d);
                last_ic = d;
            end
            if (i == 9) begin
                ic_req = 1'b0;
                lsb_req = 1'b0;
            end
            tick();
        end
        check_val("t2_idle", {31'd0, busy}, 32'd0);

        // Rollback during a fetch
        ic_req = 1'b1; ic_addr = 32'h0000_1000;
        tick();
        check_val("t3_en", {31'd0, mc_en}, 32'd1);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        tick();
        respond(32'h1234_5678);
        check_val("t3_no_done", {31'd0, ic_done}, 32'd0);
        check_val("t3_data_kept", ic_data, last_ic);
        check_val("t3_gap", {31'd0, busy}, 32'd1);
        check_val("t3_en_off", {31'd0, mc_en}, 32'd0);
        ic_req = 1'b0;
        tick();
        check_val("t3_idle", {31'd0, busy}, 32'd0);
        ic_req = 1'b1; ic_addr = 32'h0000_1004;
        tick();
        check_val("t3_next_addr", mc_addr, 32'h0000_1004);
        respond(32'hCAFE_F00D);
        check_val("t3_next_done", {31'd0, ic_done}, 32'd1);
        check_val("t3_next_data", ic_data, 32'hCAFE_F00D);
        ic_req = 1'b0;
        tick();

        // Rollback in IDLE suppresses that cycle's grant
        ic_req = 1'b1; ic_addr = 32'h0000_1008; rollback = 1'b1;
        tick();
        check_val("t3b_suppressed", {31'd0, mc_en}, 32'd0);
        rollback = 1'b0;
        tick();
        check_val("t3b_granted", mc_addr, 32'h0000_1008);
        respond(32'h0BAD_CAFE);
        check_val("t3b_done", {31'd0, ic_done}, 32'd1);
        ic_req = 1'b0;
        tick();

        // Store with rollback while busy
        lsb_set(1'b1, 32'h0003_0000, 3'd1, 32'h0000_0041);
        tick();
        check_val("t4_mc_wr", {31'd0, mc_wr}, 32'd1);
        check_val("t4_mc_len", {29'd0, mc_len}, 32'd1);
        check_val("t4_mc_addr", mc_addr, 32'h0003_0000);
        check_val("t4_mc_wdata", mc_wdata, 32'h0000_0041);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        respond(32'h9999_9999);
        check_val("t4_done", {31'd0, lsb_done}, 32'd1);
        check_val("t4_rdata_kept", lsb_rdata, last_lsb);
        lsb_req = 1'b0;
        tick();

        // Zero-length access
        lsb_set(1'b0, 32'h0000_7000, 3'd0, 32'd0);
        tick();
        check_val("t5_no_en", {31'd0, mc_en}, 32'd0);
        check_val("t5_done", {31'd0, lsb_done}, 32'd1);
        check_val("t5_gap", {31'd0, busy}, 32'd1);
        lsb_req = 1'b0;
        tick();
        check_val("t5_done_off", {31'd0, lsb_done}, 32'd0);
        check_val("t5_idle", {31'd0, busy}, 32'd0);

        // Odd length passed through
        lsb_set(1'b0, 32'h0000_6000, 3'd5, 32'd0);
        tick();
        check_val("t6_len5", {29'd0, mc_len}, 32'd5);
        respond(32'h0000_0055);
        check_val("t6_rdata", lsb_rdata, 32'h0000_0055);
        last_lsb = 32'h0000_0055;
        lsb_req = 1'b0;
        tick();

        // rdy low freezes a load and ignores mc_done
        lsb_set(1'b0, 32'h0000_4000, 3'd4, 32'd0);
        tick();
        rdy = 1'b0; mc_done = 1'b1; mc_rdata = 32'hBAD0_BAD0;
        tick();
        mc_done = 1'b0; mc_rdata = 32'd0;
        tick(); tick();
        check_val("t7_frozen_en", {31'd0, mc_en}, 32'd1);
        check_val("t7_no_done", {31'd0, lsb_done}, 32'd0);
        check_val("t7_rdata_kept", lsb_rdata, last_lsb);
        rdy = 1'b1;
        tick();
        check_val("t7_still_en", {31'd0, mc_en}, 32'd1);
        respond(32'h600D_F00D);
        check_val("t7_done", {31'd0, lsb_done}, 32'd1);
        check_val("t7_rdata", lsb_rdata, 32'h600D_F00D);
        lsb_req = 1'b0; rdy = 1'b0;
        tick(); tick();
        check_val("t7_pulse_ext", {31'd0, lsb_done}, 32'd1);
        rdy = 1'b1;
        tick();
        check_val("t7_pulse_end", {31'd0, lsb_done}, 32'd0);
        check_val("t7_idle", {31'd0, busy}, 32'd0);

        // Reset mid-load, with rdy low
        lsb_set(1'b0, 32'h0000_5000, 3'd4, 32'h0000_0077);
        tick();
        check_val("t8_en", {31'd0, mc_en}, 32'd1);
        rst = 1'b1; rdy = 1'b0;
        tick();
        check_val("t8_mc_en", {31'd0, mc_en}, 32'd0);
        check_val("t8_mc_addr", mc_addr, 32'd0);
        check_val("t8_mc_len", {29'd0, mc_len}, 32'd0);
        check_val("t8_mc_wdata", mc_wdata, 32'd0);
        check_val("t8_ic_data", ic_data, 32'd0);
        check_val("t8_lsb_rdata", lsb_rdata, 32'd0);
        check_val("t8_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0; rdy = 1'b1; lsb_req = 1'b0;
        tick();
        check_val("t8_no_done", {31'd0, lsb_done}, 32'd0);
        check_val("t8_idle_en", {31'd0, mc_en}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
